// File: rtl/constants_pkg.sv
// constants_pkg: shared writeback-arbiter sizing constants and channel indices
package constants_pkg;
  localparam int WB_NUM_CH = 2;
  localparam int WB_DEPTH = 2;
  localparam int WB_STARVE_MAX = 4;
  localparam int WB_CH_MEM = 0;
  localparam int WB_CH_MUL = 1;
  localparam int WB_DATA_W = 32;
  localparam int WB_REG_W = 5;
endpackage

// File: rtl/structure_pkg.sv
// structure_pkg: writeback entry layout {we, rd, data}
package structure_pkg;
  import constants_pkg::*;
  typedef struct packed {
    logic we;
    logic [WB_REG_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: single-channel synchronous result queue with occupancy count
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 38,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= push ? wp + PW'(1) : wp;
      rp <= pop ? rp + PW'(1) : rp;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign head = mem[rp];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: per-channel result queues merged onto one writeback port, fixed priority with starvation promotion
module wb_arbiter
  import constants_pkg::*;
  import structure_pkg::*;
#(
  parameter int NUM_CH = WB_NUM_CH,
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_W = WB_REG_W,
  parameter int DEPTH = WB_DEPTH,
  parameter int STARVE_MAX = WB_STARVE_MAX,
  localparam int CW = $clog2(NUM_CH),
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    in_valid,
  output logic [NUM_CH-1:0]    in_ready,
  input  logic [NUM_CH-1:0]    in_we,
  input  logic [NUM_CH*REG_W-1:0]  in_rd,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                 out_valid,
  output logic [CW-1:0]        out_ch,
  output logic                 out_we,
  output logic [REG_W-1:0]     out_rd,
  output logic [DATA_W-1:0]    out_data,
  output logic [NUM_CH*OW-1:0] occ
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int EW = 1 + REG_W + DATA_W;
  logic [EW-1:0] head [NUM_CH];
  logic [OW-1:0] cnt [NUM_CH];
  logic [SW-1:0] starve [NUM_CH];
  logic [NUM_CH-1:0] full, empty, pop;
  logic gnt_any, hot_any;
  logic [CW-1:0] low_idx, hot_idx, gnt_idx;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid[g] && in_ready[g]),
      .pop   (pop[g]),
      .din   ({in_we[g], in_rd[g*REG_W +: REG_W], in_data[g*DATA_W +: DATA_W]}),
      .head  (head[g]),
      .count (cnt[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
    assign in_ready[g] = !rst && !full[g];
    assign occ[g*OW +: OW] = cnt[g];
    assign pop[g] = gnt_any && gnt_idx == CW'(g);
  end
  // Scan high to low so the lowest index ends up winning in each class.
  always_comb begin
    low_idx = '0;
    hot_idx = '0;
    hot_any = 1'b0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (!empty[c]) low_idx = CW'(c);
      if (!empty[c] && starve[c] == SW'(STARVE_MAX)) begin
        hot_any = 1'b1;
        hot_idx = CW'(c);
      end
    end
  end
  assign gnt_any = |(~empty);
  assign gnt_idx = hot_any ? hot_idx : low_idx;
  always_ff @(posedge clk)
    for (int c = 0; c < NUM_CH; c++)
      starve[c] <= (rst || empty[c] || pop[c]) ? '0 : starve[c] + SW'(starve[c] != SW'(STARVE_MAX));
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch <= '0;
      out_we <= 1'b0;
      out_rd <= '0;
      out_data <= '0;
    end else begin
      out_valid <= gnt_any;
      if (gnt_any) begin
        out_ch <= gnt_idx;
        {out_we, out_rd, out_data} <= head[gnt_idx];
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of queueing, priority, starvation, back-pressure and reset
module tb_wb_arbiter;
  import constants_pkg::*;
  import structure_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] in_valid, in_ready, in_we;
  logic [9:0] in_rd;
  logic [63:0] in_data;
  logic out_valid, out_we;
  logic [0:0] out_ch;
  logic [4:0] out_rd;
  logic [31:0] out_data;
  logic [3:0] occ;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  wb_arbiter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
    .in_rd(in_rd), .in_data(in_data), .out_valid(out_valid), .out_ch(out_ch),
    .out_we(out_we), .out_rd(out_rd), .out_data(out_data), .occ(occ)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int ch, input logic v, input logic we, input logic [4:0] rd, input logic [31:0] d);
    wb_entry_t e;
    e = '{we: we, rd: rd, data: d};
    in_valid[ch] = v;
    in_we[ch] = e.we;
    in_rd[ch*5 +: 5] = e.rd;
    in_data[ch*32 +: 32] = e.data;
  endtask
  int exp_ch [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int seen;
  initial begin
    rst = 1'b1;
    in_valid = '0; in_we = '0; in_rd = '0; in_data = '0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_occ", occ, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 2'b11);
    // single push on the multiplier channel
    drive(WB_CH_MUL, 1, 1, 5, 32'hDEADBEEF);
    tick();
    in_valid = '0;
    check("single_occ1", occ, 4'b0100);
    check("single_not_yet", out_valid, 0);
    tick();
    check("single_valid", out_valid, 1);
    check("single_ch", out_ch, 1);
    check("single_rd", out_rd, 5);
    check("single_data", out_data, 32'hDEADBEEF);
    check("single_we", out_we, 1);
    tick();
    check("single_gone", out_valid, 0);
    check("single_hold", out_data, 32'hDEADBEEF);
    // non-writing entry
    drive(WB_CH_MEM, 1, 0, 7, 32'h11);
    tick();
    in_valid = '0;
    tick();
    check("nowe_valid", out_valid, 1);
    check("nowe_we", out_we, 0);
    check("nowe_rd", out_rd, 7);
    check("nowe_ch", out_ch, 0);
    tick();
    // starvation: ch0 streams, ch1 holds two entries
    drive(0, 1, 1, 1, 32'h100);
    drive(1, 1, 1, 2, 32'hA1);
    tick();
    drive(1, 1, 1, 2, 32'hA2);
    for (int i = 0; i < 10; i++) begin
      in_data[31:0] = 32'h101 + i;
      tick();
      in_valid[1] = 1'b0;
      check($sformatf("starve_ch%0d", i), out_ch, exp_ch[i]);
      if (i == 4) check("starve_a1", out_data, 32'hA1);
      if (i == 9) check("starve_a2", out_data, 32'hA2);
    end
    in_valid = '0;
    repeat (5) tick();
    check("drained", occ, 0);
    // back-pressure on ch1 while ch0 is busy
    drive(0, 1, 1, 1, 32'h200);
    drive(1, 1, 1, 3, 32'd1);
    tick();
    drive(1, 1, 1, 3, 32'd2);
    check("bp_ready1", in_ready[1], 1);
    tick();
    drive(1, 1, 1, 3, 32'd3);
    in_valid[0] = 1'b0;
    check("bp_full_ready", in_ready[1], 0);
    check("bp_occ1", occ[3:2], 2);
    tick();
    check("bp_ch0", out_ch, 0);
    tick();
    check("bp_out1", out_data, 1);
    check("bp_out1_ch", out_ch, 1);
    check("bp_ready_back", in_ready[1], 1);
    tick();
    in_valid = '0;
    check("bp_out2", out_data, 2);
    check("bp_pushpop_occ", occ[3:2], 1);
    tick();
    check("bp_out3", out_data, 3);
    check("bp_empty", occ, 0);
    tick();
    // simultaneous push/pop on ch0
    drive(0, 1, 1, 4, 32'h31);
    tick();
    drive(0, 1, 1, 4, 32'h32);
    tick();
    in_valid = '0;
    check("pp_occ0", occ[1:0], 1);
    check("pp_first", out_data, 32'h31);
    tick();
    check("pp_second", out_data, 32'h32);
    check("pp_occ0_empty", occ[1:0], 0);
    tick();
    // reset mid-operation
    drive(0, 1, 1, 8, 32'h41);
    drive(1, 1, 1, 9, 32'h51);
    tick();
    drive(0, 1, 1, 8, 32'h42);
    drive(1, 1, 1, 9, 32'h52);
    tick();
    check("mid_occ", occ, 4'b1001);
    check("mid_valid", out_valid, 1);
    rst = 1'b1;
    drive(0, 1, 1, 8, 32'h99);
    drive(1, 1, 1, 9, 32'h99);
    #1;
    check("rst_ready_low", in_ready, 0);
    tick();
    rst = 1'b0;
    in_valid = '0;
    check("mrst_valid", out_valid, 0);
    check("mrst_occ", occ, 0);
    check("mrst_fields", {out_ch, out_we, out_rd, out_data}, 0);
    seen = 0;
    repeat (5) begin
      tick();
      seen += int'(out_valid);
    end
    check("mrst_no_ghost", seen, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
